fetch_stage: RTL and testbench

- Instruction-fetch front end: owns the fetch PC (PCF) and issues requests to instruction memory over a req/ready + valid response handshake.
- Is the writer side of the IF/ID boundary: produces the registered InstrD / PCD / PCPlus4D the decode stage consumes, plus ValidD.
- Handles hazard-unit stall and flush, and execute-stage branch/jump redirect, with at most one outstanding memory request.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The master side issues req/addr; the slave side answers with ready, plus a
// one-cycle valid pulse carrying rdata.
interface fetch_stage_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     req;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     ready;
    logic                     valid;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  valid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output valid,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end. Owns the fetch PC, keeps at most one imem
// request in flight, and writes the IF/ID register (InstrD/PCD/PCPlus4D/ValidD).
// Redirects from execute kill or discard any in-flight fetch.
// Optional macro FETCH_PERF_EN adds delivery / dropped-response counters.
module fetch_stage #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     StallF,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    fetch_stage_if.master            imem,
    output logic [DATA_WIDTH-1:0]    InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_kill_cnt
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } state_e;

    state_e                   state;
    logic [ADDRESS_WIDTH-1:0] pcf;
    logic [ADDRESS_WIDTH-1:0] req_pc;
    logic                     kill;
    logic [DATA_WIDTH-1:0]    hold_buf;

    logic                     xfer;
    logic                     rsp;
    logic                     deliver;
    logic                     drop;
    logic [DATA_WIDTH-1:0]    deliver_data;
    logic [ADDRESS_WIDTH-1:0] target_al;
    logic [ADDRESS_WIDTH-1:0] req_pc_plus4;

    // Request only from REQ; reset masks it combinationally so memory never
    // sees a request while rst_n is low.
    assign imem.req  = rst_n && (state == StReq);
    assign imem.addr = pcf;

    // Decode this cycle's events: transfer, response, delivery and drop.
    always_comb begin
        xfer         = imem.req && imem.ready;
        rsp          = (state == StWait) && imem.valid;
        target_al    = PCTargetE & ~ADDRESS_WIDTH'(3);
        req_pc_plus4 = req_pc + ADDRESS_WIDTH'(4);
        deliver      = 1'b0;
        deliver_data = hold_buf;
        // A redirect in the same cycle suppresses any delivery.
        if (!PCSrcE) begin
            if (rsp && !kill && !StallF) begin
                deliver      = 1'b1;
                deliver_data = imem.rdata;
            end
            if ((state == StHold) && !StallF) begin
                deliver = 1'b1;
            end
        end
        drop = (rsp && (kill || PCSrcE)) || ((state == StHold) && PCSrcE);
    end

    // Fetch FSM, PC, and IF/ID register with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= StReq;
            pcf      <= RESET_PC;
            req_pc   <= '0;
            kill     <= 1'b0;
            hold_buf <= '0;
            InstrD   <= NOP;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else begin
            // FlushD wins over StallF and delivery; stall alone freezes IF/ID.
            if (FlushD) begin
                InstrD <= NOP;
                ValidD <= 1'b0;
            end else if (deliver) begin
                InstrD   <= deliver_data;
                PCD      <= req_pc;
                PCPlus4D <= req_pc_plus4;
                ValidD   <= 1'b1;
            end else if (!StallF) begin
                ValidD <= 1'b0;
            end

            case (state)
                StReq: begin
                    if (xfer) begin
                        req_pc <= pcf;
                        state  <= StWait;
                        // The accepted request is for the old PC; kill its response.
                        if (PCSrcE) begin
                            kill <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (imem.valid) begin
                        if (kill || PCSrcE) begin
                            kill  <= 1'b0;
                            state <= StReq;
                        end else if (StallF) begin
                            hold_buf <= imem.rdata;
                            state    <= StHold;
                        end else begin
                            state <= StReq;
                        end
                    end else if (PCSrcE) begin
                        kill <= 1'b1;
                    end
                end
                StHold: begin
                    if (PCSrcE || !StallF) begin
                        state <= StReq;
                    end
                end
                default: state <= StReq;
            endcase

            if (PCSrcE) begin
                pcf <= target_al;
            end else if (deliver) begin
                pcf <= req_pc_plus4;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Free-running event counters; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            if (deliver) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (drop) begin
                perf_kill_cnt <= perf_kill_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model answers requests, the
// reference model predicts the in-order stream of delivered PCs (restarted on
// every redirect or reset), and a monitor checks IF/ID on every clock edge.
module tb_fetch_stage;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    fetch_stage_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) imem_bus ();

    fetch_stage #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .StallF   (StallF),
        .FlushD   (FlushD),
        .PCSrcE   (PCSrcE),
        .PCTargetE(PCTargetE),
        .imem     (imem_bus),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_kill_cnt (perf_kill_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int deliv_cnt   = 0;
    int deliv_since_rst = 0;
    int first_deliv_cyc = 0;
    int last_deliv_cyc  = 0;

    // Expected upcoming delivery PCs in program order.
    logic [31:0] exp_q [$];

    int mem_ready_pct = 100;
    int mem_lat_min   = 1;
    int mem_lat_max   = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hA000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(pc + 32'(4 * i));
        end
    endtask

    // Memory model: one response per accepted request, after a random latency.
    initial begin
        logic        out_pend;
        int          cnt;
        logic [31:0] out_addr;
        out_pend       = 1'b0;
        cnt            = 0;
        out_addr       = '0;
        imem_bus.ready = 1'b0;
        imem_bus.valid = 1'b0;
        imem_bus.rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_bus.valid = 1'b0;
            if (!rst_n) begin
                out_pend       = 1'b0;
                imem_bus.ready = 1'b0;
            end else begin
                if (out_pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_bus.valid = 1'b1;
                        imem_bus.rdata = mem_data(out_addr);
                        out_pend       = 1'b0;
                    end
                end
                imem_bus.ready = ($urandom_range(99) < 32'(mem_ready_pct));
                if (imem_bus.req && imem_bus.ready) begin
                    check("single_outstanding", 32'(out_pend), 32'd0);
                    out_pend = 1'b1;
                    out_addr = imem_bus.addr;
                    cnt      = int'($urandom_range(mem_lat_max, mem_lat_min));
                end
            end
        end
    end

    // Monitor: after every edge, judge IF/ID against what that edge's inputs imply.
    initial begin
        logic        st, fl, br, rs;
        logic [31:0] p_instr, p_pc, p_pc4, p;
        logic        p_valid;
        p_instr = NOP;
        p_pc    = '0;
        p_pc4   = '0;
        p_valid = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            st = StallF;
            fl = FlushD;
            br = PCSrcE;
            rs = rst_n;
            #1;
            if (!rs) begin
                check("reset_instr", InstrD, NOP);
                check("reset_pcd", PCD, 32'd0);
                check("reset_pcplus4", PCPlus4D, 32'd0);
                check("reset_valid", 32'(ValidD), 32'd0);
                deliv_since_rst = 0;
                last_deliv_cyc  = cyc;
            end else if (fl) begin
                check("flush_instr", InstrD, NOP);
                check("flush_valid", 32'(ValidD), 32'd0);
                check("flush_pcd_hold", PCD, p_pc);
                check("flush_pcplus4_hold", PCPlus4D, p_pc4);
            end else if (st) begin
                check("stall_instr_hold", InstrD, p_instr);
                check("stall_pcd_hold", PCD, p_pc);
                check("stall_pcplus4_hold", PCPlus4D, p_pc4);
                check("stall_valid_hold", 32'(ValidD), 32'(p_valid));
            end else if (ValidD) begin
                deliv_cnt++;
                if (deliv_since_rst == 0) begin
                    first_deliv_cyc = cyc;
                end
                deliv_since_rst++;
                last_deliv_cyc = cyc;
                check("no_delivery_on_redirect", 32'(br), 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_delivery: got pc 0x%08h, expected none", PCD);
                end else begin
                    p = exp_q.pop_front();
                    check("deliver_pcd", PCD, p);
                    check("deliver_pcplus4", PCPlus4D, p + 32'd4);
                    check("deliver_instr", InstrD, mem_data(p));
                    if (exp_q.size() < 4) begin
                        exp_q.push_back(exp_q[$] + 32'd4);
                    end
                end
            end else begin
                check("idle_instr_hold", InstrD, p_instr);
                check("idle_pcd_hold", PCD, p_pc);
                check("idle_pcplus4_hold", PCPlus4D, p_pc4);
            end
            if (rs && (cyc - last_deliv_cyc > 400)) begin
                vectors++;
                miscompares++;
                $display("FAIL liveness: got no delivery for %0d cycles, expected progress",
                         cyc - last_deliv_cyc);
                last_deliv_cyc = cyc;
            end
            p_instr = InstrD;
            p_pc    = PCD;
            p_pc4   = PCPlus4D;
            p_valid = ValidD;
        end
    end

    // Advance on falling edges until imem_req reaches lvl, bounded.
    task automatic wait_req_level(input logic lvl, input string name);
        int n;
        n = 0;
        while (imem_bus.req !== lvl && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(imem_bus.req), 32'(lvl));
    endtask

    task automatic wait_delivery(input string name);
        int d0;
        int n;
        d0 = deliv_cnt;
        n  = 0;
        while (deliv_cnt == d0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(deliv_cnt - d0), 32'd1);
    endtask

    int          c0;
    int          d0;
    int          na;
    logic [31:0] addrs [3];
    logic [31:0] pexp;
    logic [31:0] a_hold;

    initial begin
        rst_n     = 1'b0;
        StallF    = 1'b0;
        FlushD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        model_restart(RST_PC);
        repeat (3) begin
            @(negedge clk);
            check("req_low_in_reset", 32'(imem_bus.req), 32'd0);
        end

        // Straight-line fetch with an always-ready, 1-cycle memory.
        mem_ready_pct = 100;
        mem_lat_min   = 1;
        mem_lat_max   = 1;
        na            = 0;
        rst_n         = 1'b1;
        c0            = cyc;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (imem_bus.req && na < 3) begin
                addrs[na] = imem_bus.addr;
                na++;
            end
            @(negedge clk);
        end
        check("addr_count", 32'(na), 32'd3);
        check("addr_seq0", addrs[0], RST_PC);
        check("addr_seq1", addrs[1], RST_PC + 32'd4);
        check("addr_seq2", addrs[2], RST_PC + 32'd8);
        check("first_delivery_cycle", 32'(first_deliv_cyc), 32'(c0 + 2));
        d0 = deliv_cnt;
        repeat (20) @(negedge clk);
        check("throughput_20_cycles", 32'(deliv_cnt - d0), 32'd10);

        // Stall while the response arrives, then release.
        wait_req_level(1'b1, "stall_find_req");
        pexp   = exp_q[0];
        StallF = 1'b1;
        repeat (4) @(negedge clk);
        StallF = 1'b0;
        @(negedge clk);
        check("stall_release_valid", 32'(ValidD), 32'd1);
        check("stall_release_pcd", PCD, pexp);
        check("stall_release_req", 32'(imem_bus.req), 32'd1);
        check("stall_release_addr", imem_bus.addr, pexp + 32'd4);

        // Redirect while a request is outstanding.
        mem_lat_min = 3;
        mem_lat_max = 3;
        wait_req_level(1'b0, "redir_wait_find_wait");
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0100;
        model_restart(32'h0000_0100);
        @(negedge clk);
        PCSrcE = 1'b0;
        wait_req_level(1'b1, "redir_wait_next_req");
        check("redir_wait_addr", imem_bus.addr, 32'h0000_0100);
        wait_delivery("redir_wait_delivered");
        check("redir_wait_pcd", PCD, 32'h0000_0100);

        // Redirect on the request-transfer cycle, misaligned target.
        mem_lat_min = 1;
        mem_lat_max = 1;
        wait_req_level(1'b1, "redir_xfer_find_req");
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0203;
        model_restart(32'h0000_0200);
        @(negedge clk);
        PCSrcE = 1'b0;
        wait_req_level(1'b1, "redir_xfer_next_req");
        check("redir_xfer_addr", imem_bus.addr, 32'h0000_0200);

        // Flush together with stall.
        a_hold = imem_bus.addr;
        StallF = 1'b1;
        FlushD = 1'b1;
        @(negedge clk);
        StallF = 1'b0;
        FlushD = 1'b0;
        check("flush_stall_instr", InstrD, NOP);
        check("flush_stall_valid", 32'(ValidD), 32'd0);
        check("flush_stall_pcf", imem_bus.addr, a_hold);

        // PC wrap at the top of the address space.
        PCSrcE    = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        model_restart(32'hFFFF_FFFC);
        @(negedge clk);
        PCSrcE = 1'b0;
        wait_delivery("wrap_delivered");
        check("wrap_pcd", PCD, 32'hFFFF_FFFC);
        check("wrap_pcplus4", PCPlus4D, 32'd0);
        check("wrap_next_req", 32'(imem_bus.req), 32'd1);
        check("wrap_next_addr", imem_bus.addr, 32'd0);

        // Reset in the middle of an outstanding request.
        mem_lat_min = 3;
        mem_lat_max = 3;
        wait_req_level(1'b0, "rst_find_wait");
        rst_n = 1'b0;
        model_restart(RST_PC);
        @(negedge clk);
        check("rst_mid_req_low", 32'(imem_bus.req), 32'd0);
        check("rst_mid_valid", 32'(ValidD), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_mid_req", 32'(imem_bus.req), 32'd1);
        check("rst_mid_addr", imem_bus.addr, RST_PC);

        // Randomized traffic.
        mem_ready_pct = 70;
        mem_lat_min   = 1;
        mem_lat_max   = 3;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            StallF    = ($urandom_range(3) == 0);
            PCSrcE    = ($urandom_range(19) == 0);
            PCTargetE = $urandom;
            if (PCSrcE) begin
                FlushD = $urandom_range(1) == 1;
                model_restart(PCTargetE & ~32'd3);
            end else begin
                FlushD = StallF && ($urandom_range(3) == 0);
            end
        end
        @(negedge clk);
        StallF        = 1'b0;
        FlushD        = 1'b0;
        PCSrcE        = 1'b0;
        mem_ready_pct = 100;
        mem_lat_min   = 1;
        mem_lat_max   = 1;
        repeat (6) @(negedge clk);
        wait_delivery("final_progress");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no completion, expected finish before 1000000");
        $fatal(1, "simulation time limit");
    end

endmodule
